cmos_power_seq: RTL and testbench

Power-up and bring-up sequencer for the OV5640 camera path. It drives cmos_pwdn/cmos_rst_n with datasheet-ordered delays, then releases the I2C register-config master and waits for its done/error. It discards the first frames after configuration, then asserts stream_en to gate the camera-to-FIFO write path. On error or timeout it restarts the whole sequence a bounded number of times.

---
 rtl/cmos_seq_pkg.sv | 78 +++++++
 rtl/sync_edge_det.sv | 40 ++++
 rtl/cmos_power_seq.sv | 189 ++++++++++++++++++
 tb/tb_cmos_power_seq.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmos_seq_pkg.sv
// -----------------------------------------------------------------------------
// cmos_seq_pkg
// Shared definitions for the OV5640 power-up / bring-up sequencer:
//   - seq_state_t : 3-bit state codes, also exported on the debug/LED port
//   - DEF_*       : default timing constants for a 27 MHz system clock
//   - seq_out_t   : bundle of the registered sequencer outputs
//   - seq_outputs : output values held while the sequencer sits in a state
// -----------------------------------------------------------------------------
package cmos_seq_pkg;

  typedef enum logic [2:0] {
    ST_PWDN  = 3'd0,
    ST_RST   = 3'd1,
    ST_BOOT  = 3'd2,
    ST_CFG   = 3'd3,
    ST_SKIP  = 3'd4,
    ST_RUN   = 3'd5,
    ST_RETRY = 3'd6,
    ST_FAIL  = 3'd7
  } seq_state_t;

  localparam int unsigned DEF_T_PWDN_CYC      = 27000;    // 1 ms
  localparam int unsigned DEF_T_RST_CYC       = 27000;    // 1 ms
  localparam int unsigned DEF_T_BOOT_CYC      = 540000;   // 20 ms
  localparam int unsigned DEF_T_CFG_TIMEOUT   = 2700000;  // 100 ms
  localparam int unsigned DEF_SKIP_FRAMES     = 3;
  localparam int unsigned DEF_T_FRAME_TIMEOUT = 2700000;  // 100 ms
  localparam int unsigned DEF_MAX_RETRY       = 3;
  localparam int          DEF_CNT_W           = 24;

  typedef struct packed {
    logic pwdn;
    logic rst_n;
    logic cfg_rst;
    logic stream_en;
    logic fail;
  } seq_out_t;

  // RETRY keeps the camera pins where CFG/SKIP/RUN left them (powered, out of
  // reset); the camera is only power-cycled once PWDN is re-entered.
  function automatic seq_out_t seq_outputs(input seq_state_t st);
    seq_out_t o;
    o = '{pwdn: 1'b0, rst_n: 1'b1, cfg_rst: 1'b1, stream_en: 1'b0, fail: 1'b0};
    case (st)
      ST_PWDN: begin
        o.pwdn  = 1'b1;
        o.rst_n = 1'b0;
      end
      ST_RST: begin
        o.rst_n = 1'b0;
      end
      ST_BOOT: begin
        o.rst_n = 1'b1;
      end
      ST_CFG, ST_SKIP: begin
        o.cfg_rst = 1'b0;
      end
      ST_RUN: begin
        o.cfg_rst   = 1'b0;
        o.stream_en = 1'b1;
      end
      ST_RETRY: begin
        o.cfg_rst = 1'b1;
      end
      ST_FAIL: begin
        o.pwdn  = 1'b1;
        o.rst_n = 1'b0;
        o.fail  = 1'b1;
      end
      default: begin
        o.pwdn  = 1'b1;
        o.rst_n = 1'b0;
      end
    endcase
    return o;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// -----------------------------------------------------------------------------
// sync_edge_det
// Brings an asynchronous strobe into the clk domain through a 2-FF
// synchronizer and produces a registered one-cycle pulse on its rising edge.
// The pulse appears 3 clk edges after the edge that first samples the pin high.
//
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset (clears all flops)
//   din    in   asynchronous input strobe
//   rise   out  one-cycle pulse per rising edge of din (registered)
// -----------------------------------------------------------------------------
module sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic din_p0;
  logic din_p1;
  logic din_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_p0 <= 1'b0;
      din_p1 <= 1'b0;
      din_p2 <= 1'b0;
      rise   <= 1'b0;
    end else begin
      // p0/p1: metastability synchronizer
      din_p0 <= din;
      din_p1 <= din_p0;
      // p2: previous synchronized value, for edge detection
      din_p2 <= din_p1;
      rise   <= din_p1 & ~din_p2;
    end
  end

endmodule

// File: rtl/cmos_power_seq.sv
// -----------------------------------------------------------------------------
// cmos_power_seq
// Power-up and bring-up sequencer for the OV5640 camera path:
//   PWDN -> RST -> BOOT (datasheet delays) -> CFG (I2C config master released)
//   -> SKIP (discard the first frames) -> RUN (stream_en gates FIFO writes).
// Config error, config timeout or a missing vsync sends it to RETRY, which
// restarts from PWDN up to MAX_RETRY times and then parks in FAIL.
//
// Ports:
//   clk         in   system clock (27 MHz)
//   rst_n       in   asynchronous active-low reset
//   cmos_vsync  in   camera vsync, asynchronous to clk
//   cfg_done    in   config master finished (level, clk domain)
//   cfg_error   in   config master NACK/error (level, clk domain)
//   cmos_pwdn   out  camera power-down, active high
//   cmos_rst_n  out  camera reset, active low
//   cfg_rst     out  holds the config master in reset while high
//   stream_en   out  enables the camera write into the FIFO
//   fail        out  sticky bring-up failure
//   retry_cnt   out  restarts performed so far (saturating)
//   state       out  current state code, for debug/LED
//
// All T_* values must be >= 1 and < 2**CNT_W; SKIP_FRAMES must be >= 1 and
// MAX_RETRY must fit in the 2-bit retry_cnt.
// -----------------------------------------------------------------------------
module cmos_power_seq
  import cmos_seq_pkg::*;
#(
  parameter int unsigned T_PWDN_CYC      = DEF_T_PWDN_CYC,
  parameter int unsigned T_RST_CYC       = DEF_T_RST_CYC,
  parameter int unsigned T_BOOT_CYC      = DEF_T_BOOT_CYC,
  parameter int unsigned T_CFG_TIMEOUT   = DEF_T_CFG_TIMEOUT,
  parameter int unsigned SKIP_FRAMES     = DEF_SKIP_FRAMES,
  parameter int unsigned T_FRAME_TIMEOUT = DEF_T_FRAME_TIMEOUT,
  parameter int unsigned MAX_RETRY       = DEF_MAX_RETRY,
  parameter int          CNT_W           = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmos_vsync,
  input  logic       cfg_done,
  input  logic       cfg_error,
  output logic       cmos_pwdn,
  output logic       cmos_rst_n,
  output logic       cfg_rst,
  output logic       stream_en,
  output logic       fail,
  output logic [1:0] retry_cnt,
  output logic [2:0] state
);

  localparam int SKIP_W = (SKIP_FRAMES > 1) ? $clog2(SKIP_FRAMES) : 1;

  // Terminal counts: a timed state lasts exactly T cycles, so it leaves on
  // the edge where the counter (cleared on entry) reads T-1.
  localparam logic [CNT_W-1:0]  PWDN_LAST  = CNT_W'(T_PWDN_CYC - 1);
  localparam logic [CNT_W-1:0]  RST_LAST   = CNT_W'(T_RST_CYC - 1);
  localparam logic [CNT_W-1:0]  BOOT_LAST  = CNT_W'(T_BOOT_CYC - 1);
  localparam logic [CNT_W-1:0]  CFG_LAST   = CNT_W'(T_CFG_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  FRAME_LAST = CNT_W'(T_FRAME_TIMEOUT - 1);
  localparam logic [SKIP_W-1:0] SKIP_LAST  = SKIP_W'(SKIP_FRAMES - 1);
  localparam logic [1:0]        RETRY_MAX  = 2'(MAX_RETRY);

  logic              vsync_rise;
  seq_state_t        state_q;
  seq_out_t          out_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [SKIP_W-1:0] skip_q;

  sync_edge_det u_vsync_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (cmos_vsync),
    .rise  (vsync_rise)
  );

  // Single registered FSM. Every transition loads the outputs of the target
  // state in the same edge, so outputs change together with state_q.
  // cnt_q doubles as the delay counter (PWDN/RST/BOOT/CFG) and as the
  // frame-gap timer (SKIP/RUN), where each vsync edge restarts it.
  // Events are always checked before the counter compare so that an event
  // landing on the timeout cycle still wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_PWDN;
      out_q     <= seq_outputs(ST_PWDN);
      cnt_q     <= '0;
      skip_q    <= '0;
      retry_cnt <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
      case (state_q)
        ST_PWDN: begin
          if (cnt_q == PWDN_LAST) begin
            state_q <= ST_RST;
            out_q   <= seq_outputs(ST_RST);
            cnt_q   <= '0;
          end
        end
        ST_RST: begin
          if (cnt_q == RST_LAST) begin
            state_q <= ST_BOOT;
            out_q   <= seq_outputs(ST_BOOT);
            cnt_q   <= '0;
          end
        end
        ST_BOOT: begin
          if (cnt_q == BOOT_LAST) begin
            state_q <= ST_CFG;
            out_q   <= seq_outputs(ST_CFG);
            cnt_q   <= '0;
          end
        end
        ST_CFG: begin
          // Error has priority over done when both are seen together.
          if (cfg_error) begin
            state_q <= ST_RETRY;
            out_q   <= seq_outputs(ST_RETRY);
            cnt_q   <= '0;
          end else if (cfg_done) begin
            state_q <= ST_SKIP;
            out_q   <= seq_outputs(ST_SKIP);
            cnt_q   <= '0;
            skip_q  <= '0;
          end else if (cnt_q == CFG_LAST) begin
            state_q <= ST_RETRY;
            out_q   <= seq_outputs(ST_RETRY);
            cnt_q   <= '0;
          end
        end
        ST_SKIP: begin
          if (vsync_rise) begin
            cnt_q <= '0;
            // Entering RUN on the last discarded edge makes stream_en rise
            // right at a frame boundary.
            if (skip_q == SKIP_LAST) begin
              state_q <= ST_RUN;
              out_q   <= seq_outputs(ST_RUN);
            end else begin
              skip_q <= skip_q + SKIP_W'(1);
            end
          end else if (cnt_q == FRAME_LAST) begin
            state_q <= ST_RETRY;
            out_q   <= seq_outputs(ST_RETRY);
            cnt_q   <= '0;
          end
        end
        ST_RUN: begin
          // cfg_done/cfg_error are deliberately ignored once streaming.
          if (vsync_rise) begin
            cnt_q <= '0;
          end else if (cnt_q == FRAME_LAST) begin
            state_q <= ST_RETRY;
            out_q   <= seq_outputs(ST_RETRY);
            cnt_q   <= '0;
          end
        end
        ST_RETRY: begin
          cnt_q <= '0;
          if (retry_cnt == RETRY_MAX) begin
            state_q <= ST_FAIL;
            out_q   <= seq_outputs(ST_FAIL);
          end else begin
            retry_cnt <= retry_cnt + 2'd1;
            state_q   <= ST_PWDN;
            out_q     <= seq_outputs(ST_PWDN);
          end
        end
        ST_FAIL: begin
          // Terminal: only rst_n leaves this state.
          cnt_q <= '0;
        end
        default: begin
          state_q <= ST_FAIL;
          out_q   <= seq_outputs(ST_FAIL);
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign cmos_pwdn  = out_q.pwdn;
  assign cmos_rst_n = out_q.rst_n;
  assign cfg_rst    = out_q.cfg_rst;
  assign stream_en  = out_q.stream_en;
  assign fail       = out_q.fail;
  assign state      = state_q;

endmodule

// File: tb/tb_cmos_power_seq.sv
// -----------------------------------------------------------------------------
// tb_cmos_power_seq
// Self-checking bench for cmos_power_seq with shortened timing. A behavioural
// model tracks the bring-up phase with time stamps and a vsync sample history,
// and every clock the DUT outputs are compared against it. Directed scenarios
// cover the power-up timing, config handshake, frame skipping, frame timeout,
// retry exhaustion and asynchronous reset; random soak runs follow.
// -----------------------------------------------------------------------------
module tb_cmos_power_seq;

  localparam int T_PWDN     = 4;
  localparam int T_RST      = 3;
  localparam int T_BOOT     = 5;
  localparam int T_CFG_TO   = 100;
  localparam int SKIP_N     = 2;
  localparam int T_FRAME_TO = 50;
  localparam int MAX_RETRY  = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmos_vsync = 1'b0;
  logic       cfg_done = 1'b0;
  logic       cfg_error = 1'b0;
  logic       cmos_pwdn;
  logic       cmos_rst_n;
  logic       cfg_rst;
  logic       stream_en;
  logic       fail;
  logic [1:0] retry_cnt;
  logic [2:0] state;

  cmos_power_seq #(
    .T_PWDN_CYC      (T_PWDN),
    .T_RST_CYC       (T_RST),
    .T_BOOT_CYC      (T_BOOT),
    .T_CFG_TIMEOUT   (T_CFG_TO),
    .SKIP_FRAMES     (SKIP_N),
    .T_FRAME_TIMEOUT (T_FRAME_TO),
    .MAX_RETRY       (MAX_RETRY),
    .CNT_W           (24)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmos_vsync (cmos_vsync),
    .cfg_done   (cfg_done),
    .cfg_error  (cfg_error),
    .cmos_pwdn  (cmos_pwdn),
    .cmos_rst_n (cmos_rst_n),
    .cfg_rst    (cfg_rst),
    .stream_en  (stream_en),
    .fail       (fail),
    .retry_cnt  (retry_cnt),
    .state      (state)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phases use the debug codes: 0 PWDN,1 RST,2 BOOT,3 CFG,4 SKIP,5 RUN,6 RETRY,7 FAIL.
  int m_phase;
  int m_tref;      // cycle of phase entry / last frame edge
  int m_frames;
  int m_retries;
  bit hist[5];     // hist[k] = vsync pin sampled k edges ago

  function automatic logic [4:0] exp_pins(input int ph);
    // {fail, stream_en, cfg_rst, cmos_rst_n, cmos_pwdn}
    return {ph == 7, ph == 5, !(ph >= 3 && ph <= 5), (ph >= 2 && ph <= 6), (ph == 0 || ph == 7)};
  endfunction

  task automatic model_reset();
    m_phase   = 0;
    m_tref    = cyc;
    m_frames  = 0;
    m_retries = 0;
    for (int k = 0; k < 5; k++) hist[k] = 1'b0;
  endtask

  task automatic model_enter(input int p);
    m_phase = p;
    m_tref  = cyc;
  endtask

  task automatic model_step();
    int  elapsed;
    bit  ev;
    cyc++;
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int k = 4; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = cmos_vsync;
    // A pin edge is acted on by the sequencer 4 edges after it is first sampled.
    ev      = hist[3] && !hist[4];
    elapsed = cyc - m_tref - 1;
    case (m_phase)
      0: if (elapsed == T_PWDN - 1) model_enter(1);
      1: if (elapsed == T_RST - 1)  model_enter(2);
      2: if (elapsed == T_BOOT - 1) model_enter(3);
      3: begin
        if (cfg_error)                    model_enter(6);
        else if (cfg_done) begin          model_enter(4); m_frames = 0; end
        else if (elapsed == T_CFG_TO - 1) model_enter(6);
      end
      4: begin
        if (ev) begin
          m_frames++;
          m_tref = cyc;
          if (m_frames == SKIP_N) model_enter(5);
        end else if (elapsed == T_FRAME_TO - 1) model_enter(6);
      end
      5: begin
        if (ev) m_tref = cyc;
        else if (elapsed == T_FRAME_TO - 1) model_enter(6);
      end
      6: begin
        if (m_retries == MAX_RETRY) model_enter(7);
        else begin
          m_retries++;
          model_enter(0);
        end
      end
      default: ;
    endcase
  endtask

  // One clock: model advances on the edge, DUT is sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("state", 32'(state), 32'(m_phase));
    chk("pins", 32'({fail, stream_en, cfg_rst, cmos_rst_n, cmos_pwdn}), 32'(exp_pins(m_phase)));
    chk("retry_cnt", 32'(retry_cnt), 32'(m_retries));
  endtask

  // ---------------- random vsync generator ----------------
  bit vs_on  = 1'b0;
  int vs_lo  = 20;
  int vs_hi  = 45;
  int vs_gap = 30;
  int vs_left = 0;

  task automatic vs_step();
    if (!vs_on) begin
      cmos_vsync = 1'b0;
      return;
    end
    if (vs_left == 0) begin
      vs_gap  = int'($urandom_range(vs_hi, vs_lo));
      vs_left = vs_gap;
    end
    cmos_vsync = (vs_left > vs_gap - 3);
    vs_left--;
  endtask

  task automatic wait_phase(input int p, input int budget, input string tag);
    int n = 0;
    while (m_phase != p && n < budget) begin
      vs_step();
      tick();
      n++;
    end
    chk(tag, 32'(state), 32'(p));
  endtask

  task automatic do_reset(input int hold);
    rst_n = 1'b0;
    cfg_done = 1'b0;
    cfg_error = 1'b0;
    cmos_vsync = 1'b0;
    vs_on = 1'b0;
    model_reset();
    repeat (hold) tick();
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    repeat (3) tick();
    chk("rst_pins", 32'({fail, stream_en, cfg_rst, cmos_rst_n, cmos_pwdn}), 32'h05);
    rst_n = 1'b1;

    // ---- power-up timing from reset release ----
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 3)  chk("s1_pwdn_hi_c4", 32'(cmos_pwdn), 32'd1);
      if (i == 4)  chk("s1_pwdn_lo_c5", 32'(cmos_pwdn), 32'd0);
      if (i == 6)  chk("s1_rstn_lo_c7", 32'(cmos_rst_n), 32'd0);
      if (i == 7)  chk("s1_rstn_hi_c8", 32'(cmos_rst_n), 32'd1);
      if (i == 11) chk("s1_cfgrst_hi_c12", 32'(cfg_rst), 32'd1);
      if (i == 12) chk("s1_cfgrst_lo_c13", 32'(cfg_rst), 32'd0);
    end

    // ---- cfg_done 10 cycles into CFG, then two frames ----
    repeat (9) tick();
    cfg_done = 1'b1;
    tick();
    cfg_done = 1'b0;
    chk("s2_skip", 32'(state), 32'd4);
    cmos_vsync = 1'b1;
    repeat (3) tick();
    cmos_vsync = 1'b0;
    repeat (27) tick();
    chk("s2_still_skip", 32'(state), 32'd4);
    cmos_vsync = 1'b1;
    repeat (3) tick();
    chk("s2_se_lo_3cyc", 32'(stream_en), 32'd0);
    cmos_vsync = 1'b0;
    tick();
    chk("s2_se_hi_4cyc", 32'(stream_en), 32'd1);
    chk("s2_run", 32'(state), 32'd5);

    // RUN with random frame gaps and config-line noise that must be ignored.
    vs_on = 1'b1; vs_lo = 20; vs_hi = 45; vs_gap = 30; vs_left = 26;
    repeat (300) begin
      vs_step();
      cfg_done  = 1'($urandom_range(1, 0));
      cfg_error = ($urandom_range(3, 0) == 0);
      tick();
    end
    cfg_done = 1'b0;
    cfg_error = 1'b0;
    chk("s2_run_hold", 32'(state), 32'd5);

    // ---- stop vsync in RUN: frame timeout ----
    begin
      int n = 0;
      while (vs_left != 0 && n < 60) begin
        vs_step();
        tick();
        n++;
      end
    end
    vs_on = 1'b0;
    cmos_vsync = 1'b1;
    repeat (3) tick();
    cmos_vsync = 1'b0;
    repeat (50) tick();
    chk("s5_se_before_to", 32'(stream_en), 32'd1);
    tick();
    chk("s5_se_after_to", 32'(stream_en), 32'd0);
    chk("s5_retry_state", 32'(state), 32'd6);
    tick();
    chk("s5_restart_pwdn", 32'(state), 32'd0);
    chk("s5_retry_cnt", 32'(retry_cnt), 32'd1);

    // ---- async reset while in SKIP ----
    wait_phase(3, 30, "s6_reach_cfg");
    repeat ($urandom_range(40, 1)) tick();
    cfg_done = 1'b1;
    tick();
    cfg_done = 1'b0;
    chk("s6_skip", 32'(state), 32'd4);
    cmos_vsync = 1'b1;
    repeat (3) tick();
    cmos_vsync = 1'b0;
    repeat (5) tick();
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("s6_async_pins", 32'({fail, stream_en, cfg_rst, cmos_rst_n, cmos_pwdn}), 32'h05);
    chk("s6_async_state", 32'(state), 32'd0);
    chk("s6_async_retry", 32'(retry_cnt), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    wait_phase(3, 30, "s6_cfg_again");
    repeat (5) tick();
    cfg_done = 1'b1;
    tick();
    cfg_done = 1'b0;
    vs_on = 1'b1; vs_lo = 15; vs_hi = 40; vs_left = 0;
    wait_phase(5, 200, "s6_run_again");
    repeat (40) begin
      vs_step();
      tick();
    end

    // ---- done and error in the same cycle: error wins ----
    do_reset(2);
    wait_phase(3, 30, "s3_reach_cfg");
    cfg_done  = 1'b1;
    cfg_error = 1'b1;
    tick();
    cfg_done  = 1'b0;
    cfg_error = 1'b0;
    chk("s3_retry", 32'(state), 32'd6);
    tick();
    chk("s3_pwdn", 32'(state), 32'd0);
    chk("s3_retry_cnt", 32'(retry_cnt), 32'd1);
    chk("s3_cmos_pwdn", 32'(cmos_pwdn), 32'd1);

    // ---- config never finishes: three timeouts then FAIL ----
    do_reset(2);
    vs_on = 1'b1; vs_lo = 10; vs_hi = 60; vs_left = 0;
    repeat (345) begin
      vs_step();
      tick();
    end
    chk("s4_fail", 32'(fail), 32'd1);
    chk("s4_state", 32'(state), 32'd7);
    chk("s4_retry_cnt", 32'(retry_cnt), 32'd2);
    repeat (30) begin
      vs_step();
      cfg_done  = 1'($urandom_range(1, 0));
      cfg_error = 1'($urandom_range(1, 0));
      tick();
    end
    chk("s4_frozen_pins", 32'({fail, stream_en, cfg_rst, cmos_rst_n, cmos_pwdn}), 32'h15);

    // ---- random soak ----
    for (int r = 0; r < 3; r++) begin
      do_reset(2);
      vs_on = 1'b1; vs_lo = 10; vs_hi = 60; vs_left = 0;
      repeat (700) begin
        vs_step();
        cfg_done  = ($urandom_range(39, 0) == 0);
        cfg_error = ($urandom_range(149, 0) == 0);
        tick();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
